// File: rtl/processor_test_monitor_pkg.sv
// processor_test_pkg: shared state encoding, default signature codes and register indices for the test monitor
package processor_test_pkg;
   typedef enum logic [2:0] {ST_RUN, ST_PASS, ST_FAIL, ST_ERROR, ST_TIMEOUT} state_t;
   localparam logic [31:0] DEF_PASS_CODE = 32'h0000_600D;
   localparam logic [31:0] DEF_FAIL_CODE = 32'h0000_DEAD;
   localparam logic [31:0] DEF_TAG_CODE  = 32'h0000_BEEF;
   localparam int DEF_DONE_REG   = 25;
   localparam int DEF_RESULT_REG = 16;
   localparam int DEF_TAG_REG    = 17;
endpackage

// File: rtl/processor_test_monitor_sat_counter.sv
// sat_counter: accumulating counter, saturating at all-ones or wrapping modulo 2^W
// Ports: i_clk/i_rst clock and async active-high reset, i_en qualifies an add of i_inc, o_cnt current value.
module sat_counter #(
   parameter int W     = 32,
   parameter int INC_W = 1,
   parameter bit SAT   = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [INC_W-1:0] i_inc,
   output logic [W-1:0]     o_cnt
);
   localparam int SW = W + 1;
   logic [W-1:0] r_cnt;
   logic [W:0]   w_sum;
   logic [W-1:0] w_next;
   always_comb begin
      w_sum  = {1'b0, r_cnt} + SW'(i_inc);
      w_next = (SAT && w_sum[W]) ? '1 : w_sum[W-1:0];
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_cnt <= '0;
      else if (i_en) r_cnt <= w_next;
   assign o_cnt = r_cnt;
endmodule

// File: rtl/processor_test_monitor.sv
// processor_test_monitor: snoops register writes, retirement and serial output to classify end of test
// Ports: i_clk/i_rst clock and async active-high reset; i_enable gates counting and evaluation;
// i_rf_* register-file write snoop; i_retire, i_pc_in, i_instr_in retirement/context; i_serial_* byte stream;
// o_done and one-hot o_pass/o_fail/o_error/o_timeout sticky status; o_*_count, o_serial_* counters;
// o_fail_pc/o_fail_instr context captured on the terminal transition.
module processor_test_monitor
   import processor_test_pkg::*;
#(
   parameter int                 DATA_W         = 32,
   parameter int                 ADDR_W         = 5,
   parameter int                 DONE_REG       = DEF_DONE_REG,
   parameter int                 RESULT_REG     = DEF_RESULT_REG,
   parameter int                 TAG_REG        = DEF_TAG_REG,
   parameter logic [DATA_W-1:0]  PASS_CODE      = DATA_W'(DEF_PASS_CODE),
   parameter logic [DATA_W-1:0]  FAIL_CODE      = DATA_W'(DEF_FAIL_CODE),
   parameter logic [DATA_W-1:0]  TAG_CODE       = DATA_W'(DEF_TAG_CODE),
   parameter int unsigned        TIMEOUT_CYCLES = 100000,
   parameter int                 CNT_W          = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_rf_wren,
   input  logic [ADDR_W-1:0] i_rf_waddr,
   input  logic [DATA_W-1:0] i_rf_wdata,
   input  logic              i_retire,
   input  logic [31:0]       i_pc_in,
   input  logic [31:0]       i_instr_in,
   input  logic              i_serial_wren,
   input  logic [7:0]        i_serial_data,
   output logic              o_done,
   output logic              o_pass,
   output logic              o_fail,
   output logic              o_error,
   output logic              o_timeout,
   output logic [CNT_W-1:0]  o_cycle_count,
   output logic [CNT_W-1:0]  o_instr_count,
   output logic [31:0]       o_fail_pc,
   output logic [31:0]       o_fail_instr,
   output logic [15:0]       o_serial_bytes,
   output logic [15:0]       o_serial_sum
);
   // Compared in 64 bits so a limit beyond the counter range never matches a saturated counter
   localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;
   state_t            r_state;
   logic [DATA_W-1:0] r_res_sh, r_tag_sh;
   logic              r_done, r_pass, r_fail, r_error, r_timeout;
   logic [31:0]       r_fail_pc, r_fail_instr;
   logic [CNT_W-1:0]  w_cycle;
   logic              w_wr, w_run, w_trig, w_tmo;
   state_t            w_cls, w_next;
   always_comb begin
      w_wr   = i_rf_wren && i_rf_waddr != '0;
      w_run  = i_enable && r_state == ST_RUN;
      w_trig = w_run && w_wr && i_rf_waddr == ADDR_W'(DONE_REG) && i_rf_wdata == DATA_W'(1);
      w_tmo  = TIMEOUT_CYCLES != 0 && w_run && 64'(w_cycle) == TO_LAST;
      w_cls  = r_tag_sh != TAG_CODE ? ST_ERROR :
               r_res_sh == PASS_CODE ? ST_PASS :
               r_res_sh == FAIL_CODE ? ST_FAIL : ST_ERROR;
      w_next = w_trig ? w_cls : w_tmo ? ST_TIMEOUT : r_state;
   end
   // Shadows keep tracking while disabled so a later done write sees current values
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_res_sh <= '0;
         r_tag_sh <= '0;
      end else if (w_wr) begin
         if (i_rf_waddr == ADDR_W'(RESULT_REG)) r_res_sh <= i_rf_wdata;
         if (i_rf_waddr == ADDR_W'(TAG_REG)) r_tag_sh <= i_rf_wdata;
      end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_state      <= ST_RUN;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail       <= 1'b0;
         r_error      <= 1'b0;
         r_timeout    <= 1'b0;
         r_fail_pc    <= '0;
         r_fail_instr <= '0;
      end else if (w_trig || w_tmo) begin
         r_state      <= w_next;
         r_done       <= 1'b1;
         r_pass       <= w_next == ST_PASS;
         r_fail       <= w_next == ST_FAIL;
         r_error      <= w_next == ST_ERROR;
         r_timeout    <= w_next == ST_TIMEOUT;
         r_fail_pc    <= i_pc_in;
         r_fail_instr <= i_instr_in;
      end
   sat_counter #(.W(CNT_W)) u_cycle (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_run), .i_inc(1'b1), .o_cnt(w_cycle));
   sat_counter #(.W(CNT_W)) u_instr (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_run && i_retire), .i_inc(1'b1), .o_cnt(o_instr_count));
   sat_counter #(.W(16)) u_bytes (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_run && i_serial_wren), .i_inc(1'b1), .o_cnt(o_serial_bytes));
   sat_counter #(.W(16), .INC_W(8), .SAT(1'b0)) u_sum (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(w_run && i_serial_wren), .i_inc(i_serial_data), .o_cnt(o_serial_sum));
   assign o_cycle_count = w_cycle;
   assign o_done        = r_done;
   assign o_pass        = r_pass;
   assign o_fail        = r_fail;
   assign o_error       = r_error;
   assign o_timeout     = r_timeout;
   assign o_fail_pc     = r_fail_pc;
   assign o_fail_instr  = r_fail_instr;
endmodule

// File: tb/tb_processor_test_monitor.sv
// tb_processor_test_monitor: scoreboard bench for default, 20-cycle-timeout and 4-bit-counter monitors
module tb_processor_test_monitor;
   typedef struct packed {
      logic [4:0]  st;
      logic [31:0] cyc;
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic enable = 1'b0;
   logic rf_wren = 1'b0;
   logic [4:0] rf_waddr = '0;
   logic [31:0] rf_wdata = '0;
   logic retire = 1'b0;
   logic [31:0] pc_in = '0;
   logic [31:0] instr_in = '0;
   logic serial_wren = 1'b0;
   logic [7:0] serial_data = '0;
   logic [2:0] done, pass, fail, error, tmo;
   logic [1:0][31:0] cyc_cnt, ins_cnt;
   logic [3:0] c4_cyc, c4_ins;
   logic [2:0][31:0] fpc, finstr;
   logic [2:0][15:0] sbytes, ssum;
   exp_t sb[$];
   int n_tests = 0;
   int n_fail = 0;
   int cyc = 0;
   always #5 clk = ~clk;
   processor_test_monitor u_main (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_rf_wren(rf_wren), .i_rf_waddr(rf_waddr),
      .i_rf_wdata(rf_wdata), .i_retire(retire), .i_pc_in(pc_in), .i_instr_in(instr_in),
      .i_serial_wren(serial_wren), .i_serial_data(serial_data), .o_done(done[0]), .o_pass(pass[0]),
      .o_fail(fail[0]), .o_error(error[0]), .o_timeout(tmo[0]), .o_cycle_count(cyc_cnt[0]),
      .o_instr_count(ins_cnt[0]), .o_fail_pc(fpc[0]), .o_fail_instr(finstr[0]),
      .o_serial_bytes(sbytes[0]), .o_serial_sum(ssum[0]));
   processor_test_monitor #(.TIMEOUT_CYCLES(20)) u_t20 (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_rf_wren(rf_wren), .i_rf_waddr(rf_waddr),
      .i_rf_wdata(rf_wdata), .i_retire(retire), .i_pc_in(pc_in), .i_instr_in(instr_in),
      .i_serial_wren(serial_wren), .i_serial_data(serial_data), .o_done(done[1]), .o_pass(pass[1]),
      .o_fail(fail[1]), .o_error(error[1]), .o_timeout(tmo[1]), .o_cycle_count(cyc_cnt[1]),
      .o_instr_count(ins_cnt[1]), .o_fail_pc(fpc[1]), .o_fail_instr(finstr[1]),
      .o_serial_bytes(sbytes[1]), .o_serial_sum(ssum[1]));
   processor_test_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(0)) u_c4 (
      .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_rf_wren(rf_wren), .i_rf_waddr(rf_waddr),
      .i_rf_wdata(rf_wdata), .i_retire(retire), .i_pc_in(pc_in), .i_instr_in(instr_in),
      .i_serial_wren(serial_wren), .i_serial_data(serial_data), .o_done(done[2]), .o_pass(pass[2]),
      .o_fail(fail[2]), .o_error(error[2]), .o_timeout(tmo[2]), .o_cycle_count(c4_cyc),
      .o_instr_count(c4_ins), .o_fail_pc(fpc[2]), .o_fail_instr(finstr[2]),
      .o_serial_bytes(sbytes[2]), .o_serial_sum(ssum[2]));
   function automatic logic [31:0] pc_of(int k);
      return 32'h0000_1000 + 32'(k) * 32'd4;
   endfunction
   function automatic logic [31:0] instr_of(int k);
      return 32'hA5A5_0000 ^ (32'(k) * 32'd7 + 32'd3);
   endfunction
   function automatic exp_t observe(int i);
      exp_t o;
      o.st = {done[i], pass[i], fail[i], error[i], tmo[i]};
      o.cyc = cyc_cnt[i];
      o.ins = ins_cnt[i];
      o.pc = fpc[i];
      o.instr = finstr[i];
      return o;
   endfunction
   function automatic exp_t mk(logic [4:0] st, int c, int n, int k);
      exp_t e;
      e.st = st;
      e.cyc = 32'(c);
      e.ins = 32'(n);
      e.pc = pc_of(k);
      e.instr = instr_of(k);
      return e;
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      pc_in = pc_of(cyc);
      instr_in = instr_of(cyc);
   endtask
   task automatic cycle(input logic wr, input logic [4:0] a, input logic [31:0] d,
                        input logic ret, input logic sw, input logic [7:0] sd);
      rf_wren = wr;
      rf_waddr = a;
      rf_wdata = d;
      retire = ret;
      serial_wren = sw;
      serial_data = sd;
      step();
      rf_wren = 1'b0;
      retire = 1'b0;
      serial_wren = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      enable = 1'b0;
      rf_wren = 1'b0;
      retire = 1'b0;
      serial_wren = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      enable = 1'b1;
      cyc = 0;
      pc_in = pc_of(0);
      instr_in = instr_of(0);
   endtask
   task automatic wait_done(input int i, input int bound, output int waited);
      waited = 0;
      while (!done[i] && waited < bound) begin
         step();
         waited++;
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({done, pass, fail, error, tmo} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_status: got %h expected 0", {done, pass, fail, error, tmo});
      end
      n_tests++;
      if ({cyc_cnt, ins_cnt, c4_cyc, c4_ins} !== '0) begin
         n_fail++;
         $display("FAIL reset_counts: got %h expected 0", {cyc_cnt, ins_cnt, c4_cyc, c4_ins});
      end
      n_tests++;
      if ({fpc, finstr, sbytes, ssum} !== '0) begin
         n_fail++;
         $display("FAIL reset_capture: got %h expected 0", {fpc, finstr, sbytes, ssum});
      end
   endtask
   task automatic test_pass();
      exp_t e, got;
      int w;
      do_reset();
      for (int k = 0; k <= 50; k++) begin
         if (k == 0) cycle(1'b1, 5'd16, 32'h600D, 1'b1, 1'b0, 8'h0);
         else if (k == 1) cycle(1'b1, 5'd17, 32'hBEEF, 1'b1, 1'b0, 8'h0);
         else if (k == 50) begin
            sb.push_back(mk(5'b11000, 51, 51, 50));
            cycle(1'b1, 5'd25, 32'd1, 1'b1, 1'b0, 8'h0);
         end else cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 8'h0);
      end
      wait_done(0, 10, w);
      n_tests++;
      if (w != 0) begin
         n_fail++;
         $display("FAIL pass_latency: got %0d extra cycles expected 0", w);
      end
      e = sb.pop_front();
      got = observe(0);
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL pass_result: got %h expected %h", got, e);
      end
      for (int k = 0; k < 5; k++) cycle(1'b1, 5'd25, 32'd1, 1'b1, 1'b1, 8'h7);
      got = observe(0);
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL pass_held: got %h expected %h", got, e);
      end
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      n_tests++;
      if ({observe(0), sbytes[0], ssum[0]} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected 0", {observe(0), sbytes[0], ssum[0]});
      end
   endtask
   task automatic test_fail();
      exp_t got;
      int w;
      do_reset();
      sb.push_back(mk(5'b10100, 3, 0, 2));
      cycle(1'b1, 5'd16, 32'hDEAD, 1'b0, 1'b0, 8'h0);
      cycle(1'b1, 5'd17, 32'hBEEF, 1'b0, 1'b0, 8'h0);
      cycle(1'b1, 5'd25, 32'd1, 1'b0, 1'b0, 8'h0);
      wait_done(0, 10, w);
      got = observe(0);
      n_tests++;
      if (got !== sb[0]) begin
         n_fail++;
         $display("FAIL fail_result: got %h expected %h", got, sb[0]);
      end
      void'(sb.pop_front());
   endtask
   task automatic test_error();
      exp_t got, e;
      int w;
      do_reset();
      cycle(1'b1, 5'd16, 32'h600D, 1'b0, 1'b0, 8'h0);
      cycle(1'b1, 5'd17, 32'h1234, 1'b0, 1'b0, 8'h0);
      cycle(1'b1, 5'd25, 32'd2, 1'b0, 1'b0, 8'h0);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 8'h0);
      cycle(1'b1, 5'd0, 32'd1, 1'b0, 1'b0, 8'h0);
      n_tests++;
      if (done[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL error_ignored_write: got done=%b expected 0", done[0]);
      end
      sb.push_back(mk(5'b10010, 6, 0, 5));
      cycle(1'b1, 5'd25, 32'd1, 1'b0, 1'b0, 8'h0);
      wait_done(0, 10, w);
      e = sb.pop_front();
      got = observe(0);
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL error_result: got %h expected %h", got, e);
      end
   endtask
   task automatic test_timeout();
      exp_t got, e;
      int w;
      do_reset();
      sb.push_back(mk(5'b10001, 20, 0, 19));
      wait_done(1, 40, w);
      n_tests++;
      if (w != 20) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d expected 20", w);
      end
      e = sb.pop_front();
      got = observe(1);
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL timeout_result: got %h expected %h", got, e);
      end
      n_tests++;
      if (done[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_default_idle: got done=%b expected 0", done[0]);
      end
      do_reset();
      for (int k = 0; k < 20; k++) begin
         if (k == 0) cycle(1'b1, 5'd16, 32'h600D, 1'b0, 1'b0, 8'h0);
         else if (k == 1) cycle(1'b1, 5'd17, 32'hBEEF, 1'b0, 1'b0, 8'h0);
         else if (k == 19) begin
            sb.push_back(mk(5'b11000, 20, 0, 19));
            cycle(1'b1, 5'd25, 32'd1, 1'b0, 1'b0, 8'h0);
         end else cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 8'h0);
      end
      wait_done(1, 5, w);
      e = sb.pop_front();
      got = observe(1);
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL done_beats_timeout: got %h expected %h", got, e);
      end
   endtask
   task automatic test_serial();
      exp_t got, e;
      int w;
      do_reset();
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 8'hFF);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 8'h02);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 8'h00);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 8'h10);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 8'h00);
      enable = 1'b0;
      cycle(1'b1, 5'd16, 32'h600D, 1'b1, 1'b1, 8'h55);
      cycle(1'b1, 5'd17, 32'hBEEF, 1'b1, 1'b1, 8'h55);
      cycle(1'b1, 5'd25, 32'd1, 1'b1, 1'b1, 8'h55);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 8'h55);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 8'h55);
      n_tests++;
      if ({sbytes[0], ssum[0]} !== {16'd3, 16'h0111}) begin
         n_fail++;
         $display("FAIL serial_counts: got %h expected %h", {sbytes[0], ssum[0]}, {16'd3, 16'h0111});
      end
      n_tests++;
      if ({ins_cnt[0], cyc_cnt[0]} !== {32'd4, 32'd5}) begin
         n_fail++;
         $display("FAIL frozen_counts: got %h expected %h", {ins_cnt[0], cyc_cnt[0]}, {32'd4, 32'd5});
      end
      n_tests++;
      if (done[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_done: got done=%b expected 0", done[0]);
      end
      enable = 1'b1;
      sb.push_back(mk(5'b11000, 6, 4, 10));
      cycle(1'b1, 5'd25, 32'd1, 1'b0, 1'b0, 8'h0);
      wait_done(0, 10, w);
      e = sb.pop_front();
      got = observe(0);
      n_tests++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL shadow_while_disabled: got %h expected %h", got, e);
      end
   endtask
   task automatic test_saturate();
      do_reset();
      for (int k = 0; k < 20; k++) cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 8'h0);
      n_tests++;
      if ({c4_cyc, c4_ins} !== 8'hFF) begin
         n_fail++;
         $display("FAIL saturate_c4: got %h expected ff", {c4_cyc, c4_ins});
      end
      n_tests++;
      if ({cyc_cnt[0], ins_cnt[0]} !== {32'd20, 32'd20}) begin
         n_fail++;
         $display("FAIL wide_counts: got %h expected %h", {cyc_cnt[0], ins_cnt[0]}, {32'd20, 32'd20});
      end
      n_tests++;
      if (done[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_disabled: got done=%b expected 0", done[2]);
      end
   endtask
   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_error();
      test_timeout();
      test_serial();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
